// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: vertical timing constants and counter widths shared by the
// horizontal and vertical VGA counters (640x480 @ 60 Hz defaults).
package vga_timing_pkg;

  // Vertical timing, in lines
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Counter widths
  localparam int unsigned VCNT_W  = 10;  // holds 0..V_TOTAL-1
  localparam int unsigned FRAME_W = 16;  // completed-frame counter
  localparam int unsigned DIV_W   = 8;   // frame divider, TICK_DIV up to 255

endpackage

// File: rtl/frame_tick_div.sv
// frame_tick_div: divides end-of-frame pulses by TICK_DIV and emits a
// registered one-cycle tick on the cycle after the EOF that completes a group.
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   eof        one-cycle end-of-frame pulse
//   frame_tick registered one-cycle pulse, once every TICK_DIV frames
module frame_tick_div #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic eof,
  output logic frame_tick
);

  import vga_timing_pkg::*;

  // Out-of-range TICK_DIV of 0 behaves like 1
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((TICK_DIV == 0) ? 0 : TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap_c;

  // Divider is at its terminal value; the next EOF clears it
  always_comb begin
    div_wrap_c = (div_cnt == DIV_LAST);
  end

  // Divider advance and tick register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= eof & div_wrap_c;
      if (eof) begin
        div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/vs_counter.sv
// vs_counter: vertical line counter for VGA timing. Advances one line per EOL
// pulse from the horizontal counter and decodes vertical sync, the visible
// window, the visible row index and end-of-frame; counts frames and produces
// a divided game-update tick.
// Ports:
//   clk        pixel clock, shared with the horizontal counter
//   rst        synchronous active-high reset
//   EOL        one-cycle end-of-line pulse
//   vSync      active-low vertical sync
//   vDisp      active-high visible-line window
//   EOF        one-cycle end-of-frame pulse (EOL on the last line)
//   vCount     current line, 0..V_TOTAL-1
//   yPos       visible row index, 0 outside the window
//   frameTick  one-cycle pulse every TICK_DIV frames, cycle after EOF
//   frameCount completed frames, wraps modulo 2^16
module vs_counter #(
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 EOL,
  output logic                                 vSync,
  output logic                                 vDisp,
  output logic                                 EOF,
  output logic [vga_timing_pkg::VCNT_W-1:0]    vCount,
  output logic [vga_timing_pkg::VCNT_W-1:0]    yPos,
  output logic                                 frameTick,
  output logic [vga_timing_pkg::FRAME_W-1:0]   frameCount
);

  localparam int unsigned CW         = vga_timing_pkg::VCNT_W;
  localparam int unsigned FW         = vga_timing_pkg::FRAME_W;
  localparam int unsigned V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned DISP_START = V_SYNC + V_BP;
  localparam int unsigned DISP_END   = DISP_START + V_ACTIVE;

  localparam logic [CW-1:0] LAST_LINE  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] SYNC_END   = CW'(V_SYNC);
  localparam logic [CW-1:0] DISP_FIRST = CW'(DISP_START);
  localparam logic [CW-1:0] DISP_STOP  = CW'(DISP_END);

  logic last_line_c;
  logic in_disp_c;
  logic eof_c;

  // Line decodes; held inactive during reset so outputs match line 0
  // even on the first reset cycle, before vCount has been cleared
  always_comb begin
    last_line_c = (vCount == LAST_LINE);
    in_disp_c   = (vCount >= DISP_FIRST) && (vCount < DISP_STOP);
    eof_c       = ~rst & EOL & last_line_c;
    vSync       = ~rst & (vCount >= SYNC_END);
    vDisp       = ~rst & in_disp_c;
    yPos        = '0;
    if (~rst && in_disp_c) begin
      yPos = vCount - DISP_FIRST;
    end
    EOF         = eof_c;
  end

  // Line counter and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vCount     <= '0;
      frameCount <= '0;
    end else begin
      if (EOL) begin
        vCount <= last_line_c ? '0 : vCount + CW'(1);
      end
      if (eof_c) begin
        frameCount <= frameCount + FW'(1);
      end
    end
  end

  // Game-update tick, divided down from EOF
  frame_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_frame_tick_div (
    .clk        (clk),
    .rst        (rst),
    .eof        (eof_c),
    .frame_tick (frameTick)
  );

endmodule

// File: tb/tb_vs_counter.sv
// tb_vs_counter: scoreboard bench for vs_counter. Two instances share the
// stimulus: dut (TICK_DIV=1) and dut3 (TICK_DIV=3). Each driven cycle pushes
// the expected post-edge state; the scenario tasks pop and compare it.
module tb_vs_counter;

  localparam int V_TOTAL = 525;

  logic        clk, rst, EOL;
  logic        vSync, vDisp, EOF, frameTick;
  logic [9:0]  vCount, yPos;
  logic [15:0] frameCount;
  logic        vSync3, vDisp3, EOF3, frameTick3;
  logic [9:0]  vCount3, yPos3;
  logic [15:0] frameCount3;

  vs_counter dut (
    .clk(clk), .rst(rst), .EOL(EOL), .vSync(vSync), .vDisp(vDisp), .EOF(EOF),
    .vCount(vCount), .yPos(yPos), .frameTick(frameTick), .frameCount(frameCount)
  );

  vs_counter #(.TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .EOL(EOL), .vSync(vSync3), .vDisp(vDisp3), .EOF(EOF3),
    .vCount(vCount3), .yPos(yPos3), .frameTick(frameTick3), .frameCount(frameCount3)
  );

  typedef struct {
    int vcount;
    int fcount;
    bit tick1;
    bit tick3;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_v = 0, m_fc = 0, m_d3 = 0;
  bit   m_eof = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_disp(input int v);
    return (v >= 35) && (v < 515);
  endfunction

  function automatic int exp_ypos(input int v);
    return exp_disp(v) ? v - 35 : 0;
  endfunction

  // Drive inputs at negedge, update the model, push expected post-edge state
  task automatic set_in(input logic e, input logic r);
    exp_t x;
    @(negedge clk);
    EOL = e;
    rst = r;
    m_eof   = !r && e && (m_v == V_TOTAL - 1);
    x.tick1 = m_eof;
    x.tick3 = m_eof && (m_d3 == 2);
    if (r) begin
      m_v = 0; m_fc = 0; m_d3 = 0;
    end else begin
      if (e) m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
      if (m_eof) begin
        m_fc = (m_fc + 1) % 65536;
        m_d3 = (m_d3 == 2) ? 0 : m_d3 + 1;
      end
    end
    x.vcount = m_v;
    x.fcount = m_fc;
    sb_q.push_back(x);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic e, input logic r);
    set_in(e, r);
    tick();
  endtask

  task automatic skip(input int n);
    repeat (n) begin
      step(1'b1, 1'b0);
      sb_q.delete(0);
    end
  endtask

  task automatic test_reset();
    exp_t x;
    set_in(1'b1, 1'b1);
    checks++; if (vSync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %0b want 0", vSync); end
    checks++; if (vDisp !== 1'b0) begin errors++; $display("FAIL reset_vdisp got %0b want 0", vDisp); end
    checks++; if (yPos !== 10'd0) begin errors++; $display("FAIL reset_ypos got %0d want 0", yPos); end
    checks++; if (EOF !== 1'b0) begin errors++; $display("FAIL reset_eof got %0b want 0", EOF); end
    tick();
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL reset_vcount got %0d want %0d", vCount, x.vcount); end
    checks++; if (frameCount !== 16'(x.fcount)) begin errors++; $display("FAIL reset_fcount got %0d want %0d", frameCount, x.fcount); end
    checks++; if (frameTick !== x.tick1) begin errors++; $display("FAIL reset_tick got %0b want %0b", frameTick, x.tick1); end
    checks++; if (frameTick3 !== x.tick3) begin errors++; $display("FAIL reset_tick3 got %0b want %0b", frameTick3, x.tick3); end
    step(1'b0, 1'b0);
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL hold_vcount got %0d want %0d", vCount, x.vcount); end
  endtask

  task automatic test_vsync();
    exp_t x;
    checks++; if (vSync !== 1'b0) begin errors++; $display("FAIL vsync_line0 got %0b want 0", vSync); end
    step(1'b1, 1'b0);
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL vsync_vcount1 got %0d want %0d", vCount, x.vcount); end
    checks++; if (vSync !== 1'b0) begin errors++; $display("FAIL vsync_line1 got %0b want 0", vSync); end
    step(1'b1, 1'b0);
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL vsync_vcount2 got %0d want %0d", vCount, x.vcount); end
    checks++; if (vSync !== 1'b1) begin errors++; $display("FAIL vsync_line2 got %0b want 1", vSync); end
  endtask

  // EOL every 4 cycles up to the last line; decodes checked on every line
  task automatic test_frame();
    exp_t x;
    while (m_v != V_TOTAL - 1) begin
      repeat (3) begin
        step(1'b0, 1'b0);
        x = sb_q.pop_front();
        checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL frame_hold got %0d want %0d", vCount, x.vcount); end
      end
      step(1'b1, 1'b0);
      x = sb_q.pop_front();
      checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL frame_vcount got %0d want %0d", vCount, x.vcount); end
      checks++; if (vDisp !== exp_disp(x.vcount)) begin errors++; $display("FAIL frame_vdisp line %0d got %0b want %0b", x.vcount, vDisp, exp_disp(x.vcount)); end
      checks++; if (yPos !== 10'(exp_ypos(x.vcount))) begin errors++; $display("FAIL frame_ypos line %0d got %0d want %0d", x.vcount, yPos, exp_ypos(x.vcount)); end
      if (x.vcount == 35) begin
        checks++; if (vDisp !== 1'b1 || yPos !== 10'd0) begin errors++; $display("FAIL disp_rise got vDisp=%0b yPos=%0d want 1/0", vDisp, yPos); end
      end
      if (x.vcount == 514) begin
        checks++; if (yPos !== 10'd479) begin errors++; $display("FAIL disp_last got %0d want 479", yPos); end
      end
      if (x.vcount == 515) begin
        checks++; if (vDisp !== 1'b0) begin errors++; $display("FAIL disp_fall got %0b want 0", vDisp); end
      end
    end
  endtask

  task automatic test_eof();
    exp_t x;
    set_in(1'b0, 1'b0);
    checks++; if (EOF !== 1'b0) begin errors++; $display("FAIL eof_no_eol got %0b want 0", EOF); end
    tick();
    sb_q.delete(0);
    set_in(1'b1, 1'b0);
    checks++; if (EOF !== m_eof) begin errors++; $display("FAIL eof_pulse got %0b want %0b", EOF, m_eof); end
    tick();
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL eof_vcount got %0d want %0d", vCount, x.vcount); end
    checks++; if (frameCount !== 16'(x.fcount)) begin errors++; $display("FAIL eof_fcount got %0d want %0d", frameCount, x.fcount); end
    checks++; if (frameTick !== x.tick1) begin errors++; $display("FAIL eof_tick got %0b want %0b", frameTick, x.tick1); end
    step(1'b0, 1'b0);
    x = sb_q.pop_front();
    checks++; if (frameTick !== x.tick1) begin errors++; $display("FAIL eof_tick_clear got %0b want %0b", frameTick, x.tick1); end
    checks++; if (frameCount !== 16'(x.fcount)) begin errors++; $display("FAIL eof_fcount_hold got %0d want %0d", frameCount, x.fcount); end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    repeat (20) begin
      step(1'b1, 1'b0);
      x = sb_q.pop_front();
      checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL b2b_vcount got %0d want %0d", vCount, x.vcount); end
    end
  endtask

  task automatic test_tick_div3();
    exp_t x;
    int pulses = 0;
    step(1'b1, 1'b1); sb_q.delete(0);
    step(1'b0, 1'b0); sb_q.delete(0);
    for (int f = 1; f <= 7; f++) begin
      for (int l = 0; l < V_TOTAL; l++) begin
        set_in(1'b1, 1'b0);
        checks++; if (EOF3 !== m_eof) begin errors++; $display("FAIL div3_eof got %0b want %0b", EOF3, m_eof); end
        tick();
        x = sb_q.pop_front();
        checks++; if (vCount3 !== 10'(x.vcount)) begin errors++; $display("FAIL div3_vcount got %0d want %0d", vCount3, x.vcount); end
        checks++; if (frameTick3 !== x.tick3) begin errors++; $display("FAIL div3_tick frame %0d line %0d got %0b want %0b", f, l, frameTick3, x.tick3); end
        checks++; if (frameTick !== x.tick1) begin errors++; $display("FAIL div1_tick frame %0d got %0b want %0b", f, frameTick, x.tick1); end
        if (l == V_TOTAL - 1) begin
          checks++; if (frameTick3 !== ((f % 3) == 0)) begin errors++; $display("FAIL div3_frame_tick frame %0d got %0b want %0b", f, frameTick3, (f % 3) == 0); end
        end
        if (frameTick3) pulses++;
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL div3_pulses got %0d want 2", pulses); end
    checks++; if (frameCount3 !== 16'd7) begin errors++; $display("FAIL div3_fcount got %0d want 7", frameCount3); end
    checks++; if (frameCount !== 16'd7) begin errors++; $display("FAIL div1_fcount got %0d want 7", frameCount); end
    checks++; if (vSync3 !== 1'b0 || vDisp3 !== 1'b0 || yPos3 !== 10'd0) begin errors++; $display("FAIL div3_line0 got vSync=%0b vDisp=%0b yPos=%0d want 0/0/0", vSync3, vDisp3, yPos3); end
  endtask

  task automatic test_reset_midframe();
    exp_t x;
    step(1'b1, 1'b1); sb_q.delete(0);
    step(1'b0, 1'b0); sb_q.delete(0);
    skip(300);
    set_in(1'b1, 1'b1);
    checks++; if (EOF !== 1'b0) begin errors++; $display("FAIL mid_rst_eof got %0b want 0", EOF); end
    tick();
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL mid_rst_vcount got %0d want %0d", vCount, x.vcount); end
    checks++; if (frameCount !== 16'(x.fcount)) begin errors++; $display("FAIL mid_rst_fcount got %0d want %0d", frameCount, x.fcount); end
    step(1'b0, 1'b0);
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount) || frameTick !== x.tick1) begin errors++; $display("FAIL mid_rst_hold got vCount=%0d tick=%0b want %0d/%0b", vCount, frameTick, x.vcount, x.tick1); end
    step(1'b1, 1'b0);
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount)) begin errors++; $display("FAIL mid_rst_resume got %0d want %0d", vCount, x.vcount); end
    // Reset on the last line together with EOL: frame abandoned, no EOF
    skip(V_TOTAL - 2);
    set_in(1'b1, 1'b1);
    checks++; if (EOF !== 1'b0) begin errors++; $display("FAIL last_rst_eof got %0b want 0", EOF); end
    tick();
    x = sb_q.pop_front();
    checks++; if (vCount !== 10'(x.vcount) || frameCount !== 16'(x.fcount)) begin errors++; $display("FAIL last_rst_state got vCount=%0d fc=%0d want %0d/%0d", vCount, frameCount, x.vcount, x.fcount); end
    checks++; if (frameTick !== 1'b0) begin errors++; $display("FAIL last_rst_tick got %0b want 0", frameTick); end
    step(1'b0, 1'b0);
    x = sb_q.pop_front();
    checks++; if (frameTick !== x.tick1) begin errors++; $display("FAIL last_rst_tick_after got %0b want %0b", frameTick, x.tick1); end
  endtask

  task automatic test_wrap();
    exp_t x;
    step(1'b1, 1'b1); sb_q.delete(0);
    skip(V_TOTAL - 1);
    force dut.frameCount = 16'hFFFF;
    #1;
    release dut.frameCount;
    m_fc = 65535;
    checks++; if (frameCount !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %0d want 65535", frameCount); end
    set_in(1'b1, 1'b0);
    checks++; if (EOF !== 1'b1) begin errors++; $display("FAIL wrap_eof got %0b want 1", EOF); end
    tick();
    x = sb_q.pop_front();
    checks++; if (frameCount !== 16'(x.fcount)) begin errors++; $display("FAIL wrap_fcount got %0d want %0d", frameCount, x.fcount); end
    checks++; if (frameCount !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", frameCount); end
  endtask

  initial begin
    rst = 1'b1;
    EOL = 1'b0;
    test_reset();
    test_vsync();
    test_frame();
    test_eof();
    test_back_to_back();
    test_tick_div3();
    test_reset_midframe();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
